// File: rtl/bp_mmu_ptw.sv
// Sv39 hardware page-table walker: services one TLB miss at a time, loads PTEs
// level by level and either fills the TLB with an accessed leaf or raises a page fault.
module bp_mmu_ptw
  #(parameter int unsigned vtag_width_p  = 27
  , parameter int unsigned ptag_width_p  = 28
  , parameter int unsigned paddr_width_p = 40
  , parameter int unsigned dword_width_p = 64
  , parameter int unsigned levels_p      = 3
  , parameter int unsigned idx_width_p   = 9
  , localparam int unsigned entry_width_lp = ptag_width_p + 7
  )
  ( input  logic                      clk_i
  , input  logic                      reset_i
  , input  logic                      flush_i
  , input  logic [ptag_width_p-1:0]   satp_ppn_i

  , input  logic                      miss_v_i
  , input  logic                      miss_instr_i
  , input  logic                      miss_load_i
  , input  logic                      miss_store_i
  , input  logic [vtag_width_p-1:0]   miss_vtag_i
  , output logic                      ready_o

  , output logic                      mem_cmd_v_o
  , output logic [paddr_width_p-1:0]  mem_cmd_paddr_o
  , input  logic                      mem_cmd_yumi_i
  , input  logic                      mem_resp_v_i
  , input  logic [dword_width_p-1:0]  mem_resp_data_i

  , output logic                      w_v_o
  , output logic [vtag_width_p-1:0]   w_vtag_o
  , output logic [entry_width_lp-1:0] w_entry_o

  , output logic                      instr_page_fault_o
  , output logic                      load_page_fault_o
  , output logic                      store_page_fault_o
  );

    typedef enum logic [2:0] {e_idle, e_send, e_wait, e_write, e_fault} state_e;

    localparam logic [1:0] top_level_lp = 2'(levels_p - 1);

    state_e                   state_r, state_n;
    logic [1:0]               level_r;
    logic                     abort_r;
    logic [vtag_width_p-1:0]  vtag_r;
    logic [2:0]               type_r;
    logic [ptag_width_p-1:0]  ppn_r;
    logic [5:0]               flags_r;

    logic                     pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    logic [ptag_width_p-1:0]  pte_ppn;
    logic                     pte_leaf, pte_fault, misaligned;
    logic [ptag_width_p-1:0]  lvl_mask;
    logic [idx_width_p-1:0]   vpn_sel;
    int unsigned              lvl_shift;
    logic                     unused_pte_bits;

    assign pte_v   = mem_resp_data_i[0];
    assign pte_r   = mem_resp_data_i[1];
    assign pte_w   = mem_resp_data_i[2];
    assign pte_x   = mem_resp_data_i[3];
    assign pte_u   = mem_resp_data_i[4];
    assign pte_a   = mem_resp_data_i[6];
    assign pte_d   = mem_resp_data_i[7];
    assign pte_ppn = mem_resp_data_i[10 +: ptag_width_p];
    assign unused_pte_bits = ^{mem_resp_data_i[dword_width_p-1:10+ptag_width_p],
                               mem_resp_data_i[9:8], mem_resp_data_i[5]};

    // Mask covers the VPN bits that a superpage at the current level passes through.
    assign lvl_shift  = idx_width_p * level_r;
    assign lvl_mask   = ~({ptag_width_p{1'b1}} << lvl_shift);
    assign vpn_sel    = idx_width_p'(vtag_r >> lvl_shift);
    assign misaligned = |(pte_ppn & lvl_mask);
    assign pte_leaf   = pte_r | pte_x;
    assign pte_fault  = ~pte_v | (pte_w & ~pte_r)
                      | (pte_leaf & (~pte_a | misaligned))
                      | (~pte_leaf & (level_r == 2'd0));

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle:  if (miss_v_i && !flush_i) state_n = e_send;
            e_send:  if (mem_cmd_yumi_i)       state_n = e_wait;
                     else if (flush_i)         state_n = e_idle;
            e_wait:  if (mem_resp_v_i) begin
                         if (abort_r || flush_i) state_n = e_idle;
                         else if (pte_fault)     state_n = e_fault;
                         else if (pte_leaf)      state_n = e_write;
                         else                    state_n = e_send;
                     end
            e_write: state_n = e_idle;
            e_fault: state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    // A flush coinciding with yumi still owes us a response, so it is tracked as an abort.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_r <= top_level_lp;
            abort_r <= 1'b0;
            vtag_r  <= '0;
            type_r  <= '0;
            ppn_r   <= '0;
            flags_r <= '0;
        end else begin
            case (state_r)
                e_idle: if (miss_v_i && !flush_i) begin
                    vtag_r  <= miss_vtag_i;
                    type_r  <= {miss_store_i, miss_load_i, miss_instr_i};
                    level_r <= top_level_lp;
                    ppn_r   <= satp_ppn_i;
                    abort_r <= 1'b0;
                end
                e_send: if (mem_cmd_yumi_i && flush_i) abort_r <= 1'b1;
                e_wait: begin
                    if (flush_i) abort_r <= 1'b1;
                    if (mem_resp_v_i) begin
                        ppn_r   <= pte_ppn;
                        flags_r <= {pte_a, pte_d, pte_u, pte_x, pte_w, pte_r};
                        if (state_n == e_send) level_r <= level_r - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready_o            = (state_r == e_idle);
        mem_cmd_v_o        = (state_r == e_send);
        mem_cmd_paddr_o    = paddr_width_p'({ppn_r, vpn_sel, 3'b000});
        w_v_o              = (state_r == e_write);
        w_vtag_o           = vtag_r;
        w_entry_o          = {(ppn_r & ~lvl_mask) | (ptag_width_p'(vtag_r) & lvl_mask),
                              level_r == top_level_lp, flags_r};
        instr_page_fault_o = (state_r == e_fault) & type_r[0];
        load_page_fault_o  = (state_r == e_fault) & type_r[1];
        store_page_fault_o = (state_r == e_fault) & type_r[2];
    end

endmodule

// File: tb/tb_bp_mmu_ptw.sv
// Bench for bp_mmu_ptw: directed vector table, flush/reset/backpressure sequences,
// and randomized page tables checked against an arithmetic Sv39 walk model.
module tb_bp_mmu_ptw;

    logic        clk = 1'b0;
    logic        reset_i, flush_i;
    logic [27:0] satp_ppn_i;
    logic        miss_v_i, miss_instr_i, miss_load_i, miss_store_i;
    logic [26:0] miss_vtag_i;
    logic        ready_o;
    logic        mem_cmd_v_o;
    logic [39:0] mem_cmd_paddr_o;
    logic        mem_cmd_yumi_i, mem_resp_v_i;
    logic [63:0] mem_resp_data_i;
    logic        w_v_o;
    logic [26:0] w_vtag_o;
    logic [34:0] w_entry_o;
    logic        instr_page_fault_o, load_page_fault_o, store_page_fault_o;
    logic [2:0]  faults;

    always #5 clk = ~clk;
    assign faults = {store_page_fault_o, load_page_fault_o, instr_page_fault_o};

    bp_mmu_ptw #(.vtag_width_p(27), .ptag_width_p(28), .paddr_width_p(40)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .satp_ppn_i(satp_ppn_i),
        .miss_v_i(miss_v_i), .miss_instr_i(miss_instr_i), .miss_load_i(miss_load_i),
        .miss_store_i(miss_store_i), .miss_vtag_i(miss_vtag_i), .ready_o(ready_o),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_paddr_o(mem_cmd_paddr_o),
        .mem_cmd_yumi_i(mem_cmd_yumi_i), .mem_resp_v_i(mem_resp_v_i),
        .mem_resp_data_i(mem_resp_data_i), .w_v_o(w_v_o), .w_vtag_o(w_vtag_o),
        .w_entry_o(w_entry_o), .instr_page_fault_o(instr_page_fault_o),
        .load_page_fault_o(load_page_fault_o), .store_page_fault_o(store_page_fault_o));

    int n_cmp = 0;
    int n_fail = 0;

    logic [63:0] mem [logic [39:0]];
    logic [39:0] got_addr_q[$];
    logic [39:0] exp_addr_q[$];
    int          yumi_delay = 0;
    int          resp_delay = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [39:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic logic [63:0] pte_mk(input logic [27:0] ppn, input logic [7:0] fl);
        return (64'(ppn) << 10) | 64'(fl);
    endfunction

    // Memory side: yumi after yumi_delay cycles of valid, response resp_delay+1 cycles later.
    initial begin
        logic        pend, seen;
        int          pend_cnt, hold;
        logic [39:0] pend_addr, first;
        mem_cmd_yumi_i = 1'b0; mem_resp_v_i = 1'b0; mem_resp_data_i = '0;
        pend = 1'b0; seen = 1'b0; pend_cnt = 0; hold = 0; pend_addr = '0; first = '0;
        forever begin
            @(negedge clk);
            if (pend && pend_cnt == 0) begin
                mem_resp_v_i = 1'b1; mem_resp_data_i = rd(pend_addr); pend = 1'b0;
            end else begin
                mem_resp_v_i = 1'b0; mem_resp_data_i = {$urandom, $urandom};
                if (pend) pend_cnt--;
            end
            mem_cmd_yumi_i = 1'b0;
            if (mem_cmd_v_o) begin
                if (!seen) begin seen = 1'b1; hold = yumi_delay; first = mem_cmd_paddr_o; end
                else check("paddr_stable", 64'(mem_cmd_paddr_o), 64'(first));
                if (hold == 0) begin
                    mem_cmd_yumi_i = 1'b1; seen = 1'b0; pend = 1'b1;
                    pend_cnt = resp_delay; pend_addr = mem_cmd_paddr_o;
                    got_addr_q.push_back(mem_cmd_paddr_o);
                end else hold--;
            end else seen = 1'b0;
        end
    end

    // Reference walk: plain arithmetic over page numbers, spans and remainders.
    function automatic void model_walk(input logic [27:0] satp, input logic [26:0] vtag,
                                       input logic [2:0] typ, output logic exp_w,
                                       output logic [34:0] exp_entry, output logic [2:0] exp_fault);
        longint unsigned ppn, vpn, addr, pp, span;
        logic [63:0] pte;
        ppn = 64'(satp); exp_w = 1'b0; exp_entry = '0; exp_fault = '0;
        exp_addr_q.delete();
        for (int lvl = 2; lvl >= 0; lvl--) begin
            span = 64'd1 << (9 * lvl);
            vpn  = (64'(vtag) / span) % 512;
            addr = ppn * 4096 + vpn * 8;
            exp_addr_q.push_back(40'(addr));
            pte  = rd(40'(addr));
            pp   = (pte >> 10) % (64'd1 << 28);
            if (!pte[0] || (pte[2] && !pte[1])) begin exp_fault = typ; return; end
            if (pte[1] || pte[3]) begin
                if (!pte[6] || (pp % span) != 0) begin exp_fault = typ; return; end
                exp_w = 1'b1;
                exp_entry = {28'(pp + 64'(vtag) % span), lvl == 2,
                             pte[6], pte[7], pte[4], pte[3], pte[2], pte[1]};
                return;
            end
            if (lvl == 0) begin exp_fault = typ; return; end
            ppn = pp;
        end
    endfunction

    task automatic start_miss(input logic [26:0] vtag, input logic [2:0] typ);
        @(negedge clk);
        miss_v_i = 1'b1; miss_vtag_i = vtag;
        {miss_store_i, miss_load_i, miss_instr_i} = typ;
        @(posedge clk);
        @(negedge clk);
        miss_v_i = 1'b0;
    endtask

    task automatic run_walk(input logic [26:0] vtag, input logic [2:0] typ, output logic got_w,
                            output logic [34:0] got_entry, output logic [2:0] got_fault,
                            output int got_cyc);
        got_w = 1'b0; got_entry = '0; got_fault = '0; got_cyc = -1;
        start_miss(vtag, typ);
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (w_v_o || (faults != 3'b000)) begin
                check("fill_fault_exclusive", 64'(w_v_o && (faults != 3'b000)), 64'd0);
                got_w = w_v_o; got_entry = w_entry_o; got_fault = faults; got_cyc = c;
                if (w_v_o) check("w_vtag", 64'(w_vtag_o), 64'(vtag));
                break;
            end
        end
        if (got_cyc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL walk_timeout: got no fill/fault expected one within 400 cycles");
        end else begin
            @(negedge clk); #1;
            check("pulse_then_idle", 64'({ready_o, w_v_o, faults}), 64'b10000);
        end
    endtask

    typedef struct {
        logic [26:0] vtag;  logic [2:0] typ;
        logic [63:0] pte2;  logic [63:0] pte1;  logic [63:0] pte0;
        logic [39:0] exp_a0; logic exp_w; logic [27:0] exp_ptag; logic exp_gp;
        logic [5:0]  exp_fl; logic [2:0] exp_fault; int exp_cyc;
    } vec_t;
    vec_t vecs[9];

    task automatic load_table(input vec_t v);
        logic [27:0] p1, p0;
        mem.delete();
        mem[{28'h80000, v.vtag[26:18], 3'b000}] = v.pte2;
        p1 = v.pte2[37:10];
        mem[{p1, v.vtag[17:9], 3'b000}] = v.pte1;
        p0 = v.pte1[37:10];
        mem[{p0, v.vtag[8:0], 3'b000}] = v.pte0;
    endtask

    task automatic run_vec(input int i, input int exp_cyc, input string tag);
        logic gw; logic [34:0] ge; logic [2:0] gf; int gc;
        load_table(vecs[i]);
        satp_ppn_i = 28'h80000;
        got_addr_q.delete();
        run_walk(vecs[i].vtag, vecs[i].typ, gw, ge, gf, gc);
        check($sformatf("%s%0d_w", tag, i), 64'(gw), 64'(vecs[i].exp_w));
        check($sformatf("%s%0d_fault", tag, i), 64'(gf), 64'(vecs[i].exp_fault));
        check($sformatf("%s%0d_cycle", tag, i), 64'(gc), 64'(exp_cyc));
        check($sformatf("%s%0d_addr0", tag, i),
              got_addr_q.size() > 0 ? 64'(got_addr_q[0]) : 64'hDEAD, 64'(vecs[i].exp_a0));
        if (vecs[i].exp_w) begin
            check($sformatf("%s%0d_ptag", tag, i), 64'(ge[34:7]), 64'(vecs[i].exp_ptag));
            check($sformatf("%s%0d_gp", tag, i), 64'(ge[6]), 64'(vecs[i].exp_gp));
            check($sformatf("%s%0d_flags", tag, i), 64'(ge[5:0]), 64'(vecs[i].exp_fl));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ptr1, ptr2, pte;
        logic [27:0] satp, ppn;
        logic [26:0] vtag;
        logic [2:0]  typ, gf, ef;
        logic        gw, ew;
        logic [34:0] ge, ee;
        logic [39:0] addr;
        int          gc, resp_c, bad, kind;

        ptr1 = pte_mk(28'h80001, 8'h01);
        ptr2 = pte_mk(28'h80002, 8'h01);
        vecs[0] = '{27'h0000401, 3'b010, ptr1, ptr2, pte_mk(28'h81234, 8'hCF),
                    40'h80000000, 1'b1, 28'h81234, 1'b0, 6'h37, 3'b000, 7};
        vecs[1] = '{27'h0012345, 3'b010, pte_mk(28'h40000, 8'h43), 64'd0, 64'd0,
                    40'h80000000, 1'b1, 28'h52345, 1'b1, 6'h21, 3'b000, 3};
        vecs[2] = '{27'h0000401, 3'b010, ptr1, pte_mk(28'h90001, 8'hCF), 64'd0,
                    40'h80000000, 1'b0, 28'h0, 1'b0, 6'h0, 3'b010, 5};
        vecs[3] = '{27'h0000401, 3'b001, ptr1, ptr2, pte_mk(28'h81234, 8'hCE),
                    40'h80000000, 1'b0, 28'h0, 1'b0, 6'h0, 3'b001, 7};
        vecs[4] = '{27'h0000401, 3'b100, pte_mk(28'h40000, 8'h45), 64'd0, 64'd0,
                    40'h80000000, 1'b0, 28'h0, 1'b0, 6'h0, 3'b100, 3};
        vecs[5] = '{27'h0000401, 3'b010, ptr1, ptr2, pte_mk(28'h81234, 8'h0F),
                    40'h80000000, 1'b0, 28'h0, 1'b0, 6'h0, 3'b010, 7};
        vecs[6] = '{27'h0000401, 3'b100, ptr1, ptr2, pte_mk(28'h81234, 8'h01),
                    40'h80000000, 1'b0, 28'h0, 1'b0, 6'h0, 3'b100, 7};
        vecs[7] = '{27'h0000401, 3'b100, ptr1, ptr2, pte_mk(28'h81234, 8'h47),
                    40'h80000000, 1'b1, 28'h81234, 1'b0, 6'h23, 3'b000, 7};
        vecs[8] = '{27'h0000401, 3'b001, ptr1, pte_mk(28'h80200, 8'h5B), 64'd0,
                    40'h80000000, 1'b1, 28'h80201, 1'b0, 6'h2D, 3'b000, 5};

        reset_i = 1'b1; flush_i = 1'b0; satp_ppn_i = 28'h80000;
        miss_v_i = 1'b0; miss_instr_i = 1'b0; miss_load_i = 1'b0; miss_store_i = 1'b0;
        miss_vtag_i = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("reset_outputs", 64'({ready_o, mem_cmd_v_o, w_v_o, faults}), 64'b100000);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i].exp_cyc, "vec");

        // Flush while waiting: the response is still drained, nothing is filled or faulted.
        load_table(vecs[0]); resp_delay = 5; got_addr_q.delete();
        start_miss(vecs[0].vtag, vecs[0].typ);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        resp_c = -1; bad = 0;
        for (int c = 3; c <= 20; c++) begin
            if (c > 3) @(negedge clk);
            #1;
            if (w_v_o || faults != 3'b000) bad++;
            if (resp_c >= 0 && c == resp_c + 1) check("flush_ready_after_resp", 64'(ready_o), 64'd1);
            if (mem_resp_v_i) begin
                resp_c = c;
                check("flush_busy_at_resp", 64'(ready_o), 64'd0);
            end
        end
        check("flush_no_fill_fault", 64'(bad), 64'd0);
        check("flush_resp_cycle", 64'(resp_c), 64'd7);
        check("flush_cmd_count", 64'(got_addr_q.size()), 64'd1);
        resp_delay = 0;

        yumi_delay = 10;
        run_vec(0, 37, "yumi");
        yumi_delay = 0;

        // Reset during the wait for a response; the late response must be ignored.
        load_table(vecs[0]); resp_delay = 3;
        start_miss(vecs[0].vtag, vecs[0].typ);
        @(negedge clk);
        #1;
        check("rst_pre_in_wait", 64'({ready_o, mem_cmd_v_o}), 64'b00);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("rst_idle", 64'(ready_o), 64'd1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (!ready_o || mem_cmd_v_o || w_v_o || faults != 3'b000) bad++;
        end
        check("rst_late_resp_ignored", 64'(bad), 64'd0);
        resp_delay = 0;
        run_vec(0, 7, "post_rst");

        for (int k = 0; k < 40; k++) begin
            mem.delete();
            satp = 28'($urandom);
            vtag = 27'($urandom);
            typ  = 3'(1 << $urandom_range(0, 2));
            yumi_delay = $urandom_range(0, 2);
            resp_delay = $urandom_range(0, 2);
            ppn = satp;
            for (int lvl = 2; lvl >= 0; lvl--) begin
                addr = {ppn, 9'(vtag >> (9 * lvl)), 3'b000};
                pte  = {$urandom, $urandom};
                kind = $urandom_range(0, 7);
                case (kind)
                    0:       pte[0] = 1'b0;
                    1:       begin pte[0] = 1'b1; pte[2] = 1'b1; pte[1] = 1'b0; end
                    2, 3, 4: begin pte[0] = 1'b1; pte[3:1] = 3'b000; end
                    default: begin
                        pte[0] = 1'b1;
                        if (pte[3:1] == 3'b000) pte[1] = 1'b1;
                        pte[6] = ($urandom_range(0, 3) != 0);
                        if ($urandom_range(0, 1) == 1)
                            pte = pte & ~(((64'd1 << (9 * lvl)) - 64'd1) << 10);
                    end
                endcase
                mem[addr] = pte;
                ppn = pte[37:10];
            end
            satp_ppn_i = satp;
            got_addr_q.delete();
            model_walk(satp, vtag, typ, ew, ee, ef);
            run_walk(vtag, typ, gw, ge, gf, gc);
            check($sformatf("rnd%0d_w", k), 64'(gw), 64'(ew));
            check($sformatf("rnd%0d_fault", k), 64'(gf), 64'(ef));
            if (ew) check($sformatf("rnd%0d_entry", k), 64'(ge), 64'(ee));
            check($sformatf("rnd%0d_ncmd", k), 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
            for (int j = 0; j < exp_addr_q.size() && j < got_addr_q.size(); j++)
                check($sformatf("rnd%0d_addr%0d", k, j), 64'(got_addr_q[j]), 64'(exp_addr_q[j]));
        end
        yumi_delay = 0; resp_delay = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
